// File: rtl/hc4_pkg.sv
// hc4 program loader shared types and constants.
// Loader FSM states, default widths and the NOP word.
package hc4_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

  localparam int ADDR_W_DEF  = 12;
  localparam int INSTR_W_DEF = 8;
  localparam int DEPTH_DEF   = 4096;

  localparam logic [INSTR_W_DEF-1:0] NOP = '0;

endpackage

// File: rtl/hc4_prog_loader_if.sv
// Byte-stream load channel into the hc4 program loader.
// Valid/ready handshake with a last-byte qualifier.
interface hc4_prog_loader_if #(
  parameter int INSTR_W = 8
);

  logic               ld_valid;
  logic [INSTR_W-1:0] ld_data;
  logic               ld_last;
  logic               ld_ready;

  modport master (
    output ld_valid,
    output ld_data,
    output ld_last,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_data,
    input  ld_last,
    output ld_ready
  );

endinterface

// File: rtl/hc4_prog_ram.sv
// hc4 program memory: one sync write port, one registered read.
// A disabled read loads NOP so the core never sees stale words.
module hc4_prog_ram
  import hc4_pkg::*;
#(
  parameter int DEPTH   = 4096,
  parameter int INSTR_W = 8,
  parameter int AW      = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic [AW-1:0]      wa_i,
  input  logic [INSTR_W-1:0] wd_i,
  input  logic               re_i,
  input  logic [AW-1:0]      ra_i,
  output logic [INSTR_W-1:0] rd_o
);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [INSTR_W-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[wa_i] <= wd_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= INSTR_W'(NOP);
    end else if (re_i) begin
      rd_q <= mem[ra_i];
    end else begin
      rd_q <= INSTR_W'(NOP);
    end
  end

  assign rd_o = rd_q;

endmodule

// File: rtl/hc4_prog_loader.sv
// hc4 program loader: serves fetches and reloads program memory
// from a byte stream while holding the core in reset.
module hc4_prog_loader
  import hc4_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int INSTR_W    = INSTR_W_DEF,
  parameter int RESET_HOLD = 4
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                load_start,
  hc4_prog_loader_if.slave    ld,
  input  logic [ADDR_W-1:0]   pc_in,
  output logic [INSTR_W-1:0]  instr_out,
  output logic                cpu_nReset,
  output logic                load_done,
  output logic [ADDR_W-1:0]   load_count,
  output logic                load_ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam int CW = ADDR_W + 1;

  state_e         state_q, state_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic           done_q, done_d;

  logic           ready;
  logic           accept;
  logic           we;
  logic           at_end;
  logic           re;

  assign ready  = (state_q == ST_LOAD);
  assign accept = ld.ld_valid & ready;
  assign at_end = (addr_q == AW'(DEPTH - 1));

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    we      = 1'b0;
    unique case (state_q)
      ST_HOLD: begin
        if (load_start) begin
          state_d = ST_LOAD;
          hold_d  = '0;
          addr_d  = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else if (hold_q == HW'(RESET_HOLD - 1)) begin
          state_d = ST_RUN;
          hold_d  = '0;
        end else begin
          hold_d  = hold_q + HW'(1);
        end
      end
      ST_RUN: begin
        if (load_start) begin
          state_d = ST_LOAD;
          addr_d  = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          we    = 1'b1;
          cnt_d = cnt_q + CW'(1);
          // last slot ends the load even without ld_last
          if (ld.ld_last || at_end) begin
            state_d = ST_HOLD;
            hold_d  = '0;
            done_d  = 1'b1;
            ovf_d   = ~ld.ld_last;
          end else begin
            addr_d  = addr_q + AW'(1);
          end
        end
      end
      default: begin
        state_d = ST_HOLD;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_HOLD;
      hold_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign re = (state_q == ST_RUN) &&
              ({1'b0, pc_in} < CW'(DEPTH));

  hc4_prog_ram #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W),
    .AW      (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (nReset),
    .we_i  (we),
    .wa_i  (addr_q),
    .wd_i  (ld.ld_data),
    .re_i  (re),
    .ra_i  (pc_in[AW-1:0]),
    .rd_o  (instr_out)
  );

  assign ld.ld_ready = ready;
  assign cpu_nReset  = (state_q == ST_RUN);
  assign load_done   = done_q;
  assign load_ovf    = ovf_q;
  // a full 2**ADDR_W load cannot be shown, so clamp it
  assign load_count  = cnt_q[ADDR_W] ? '1 : cnt_q[ADDR_W-1:0];

endmodule

// File: tb/tb_hc4_prog_loader.sv
// Directed bench for hc4_prog_loader (DEPTH=8, RESET_HOLD=4).
module tb_hc4_prog_loader;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 8;
  localparam int IW     = 8;

  logic              clk = 1'b0;
  logic              nReset;
  logic              load_start;
  logic [ADDR_W-1:0] pc_in;
  logic [IW-1:0]     instr_out;
  logic              cpu_nReset;
  logic              load_done;
  logic [ADDR_W-1:0] load_count;
  logic              load_ovf;

  int n_chk  = 0;
  int n_fail = 0;

  hc4_prog_loader_if #(.INSTR_W(IW)) ld_if ();

  hc4_prog_loader #(
    .ADDR_W     (ADDR_W),
    .DEPTH      (DEPTH),
    .INSTR_W    (IW),
    .RESET_HOLD (4)
  ) dut (
    .clk        (clk),
    .nReset     (nReset),
    .load_start (load_start),
    .ld         (ld_if),
    .pc_in      (pc_in),
    .instr_out  (instr_out),
    .cpu_nReset (cpu_nReset),
    .load_done  (load_done),
    .load_count (load_count),
    .load_ovf   (load_ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_run();
    for (int k = 0; k < 12; k++) begin
      step();
      if (cpu_nReset === 1'b1) break;
    end
    chk("wait_run", 32'(cpu_nReset), 32'd1);
  endtask

  task automatic fetch(input int a, input logic [7:0] exp);
    pc_in = ADDR_W'(a);
    step();
    chk($sformatf("fetch[%0d]", a), 32'(instr_out), 32'(exp));
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    ld_if.ld_valid = 1'b1;
    ld_if.ld_data  = d;
    ld_if.ld_last  = last;
    step();
    ld_if.ld_valid = 1'b0;
    ld_if.ld_last  = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  initial begin
    nReset         = 1'b0;
    load_start     = 1'b0;
    pc_in          = '0;
    ld_if.ld_valid = 1'b0;
    ld_if.ld_data  = '0;
    ld_if.ld_last  = 1'b0;
    #2;
    chk("rst_cpu_nReset", 32'(cpu_nReset), 32'd0);
    chk("rst_ready", 32'(ld_if.ld_ready), 32'd0);
    chk("rst_instr", 32'(instr_out), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_count", 32'(load_count), 32'd0);
    chk("rst_ovf", 32'(load_ovf), 32'd0);

    step();
    nReset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_cpu_nReset", 32'(cpu_nReset), 32'd0);
      chk("hold_instr", 32'(instr_out), 32'd0);
    end
    step();
    chk("run_cpu_nReset", 32'(cpu_nReset), 32'd1);

    // three-byte back-to-back load
    start_load();
    chk("ld1_cpu_nReset", 32'(cpu_nReset), 32'd0);
    chk("ld1_ready", 32'(ld_if.ld_ready), 32'd1);
    chk("ld1_instr_nop", 32'(instr_out), 32'd0);
    ld_if.ld_valid = 1'b1;
    ld_if.ld_data  = 8'h11;
    step();
    ld_if.ld_data  = 8'h22;
    step();
    send(8'h33, 1'b1);
    chk("ld1_done", 32'(load_done), 32'd1);
    chk("ld1_count", 32'(load_count), 32'd3);
    chk("ld1_ready_low", 32'(ld_if.ld_ready), 32'd0);
    step();
    chk("ld1_done_pulse", 32'(load_done), 32'd0);
    step();
    step();
    chk("ld1_hold3", 32'(cpu_nReset), 32'd0);
    step();
    chk("ld1_run", 32'(cpu_nReset), 32'd1);
    fetch(1, 8'h22);
    fetch(0, 8'h11);
    fetch(2, 8'h33);

    // gapped valid, five bytes
    start_load();
    for (int i = 0; i < 5; i++) begin
      send(8'hA0 + 8'(i), i == 4);
      chk("gap_count", 32'(load_count), 32'(i + 1));
      step();
      chk("gap_count_idle", 32'(load_count), 32'(i + 1));
    end
    wait_run();
    for (int i = 0; i < 5; i++) fetch(i, 8'hA0 + 8'(i));

    // overflow: ten bytes offered, no ld_last
    start_load();
    ld_if.ld_valid = 1'b1;
    ld_if.ld_last  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("ovf_ready", 32'(ld_if.ld_ready), 32'(i < 8));
      ld_if.ld_data = 8'h50 + 8'(i);
      step();
      if (i == 7) begin
        chk("ovf_flag", 32'(load_ovf), 32'd1);
        chk("ovf_count", 32'(load_count), 32'd8);
        chk("ovf_done", 32'(load_done), 32'd1);
      end
    end
    ld_if.ld_valid = 1'b0;
    chk("ovf_count_sat", 32'(load_count), 32'd8);
    wait_run();
    chk("ovf_sticky", 32'(load_ovf), 32'd1);
    for (int i = 0; i < 8; i++) fetch(i, 8'h50 + 8'(i));
    fetch(DEPTH, 8'h00);

    // load_start during LOAD is ignored
    start_load();
    chk("ign_ovf_clr", 32'(load_ovf), 32'd0);
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("ign_count", 32'(load_count), 32'd2);
    chk("ign_ready", 32'(ld_if.ld_ready), 32'd1);
    send(8'h63, 1'b1);
    chk("ign_count_end", 32'(load_count), 32'd3);
    wait_run();
    fetch(0, 8'h61);
    fetch(1, 8'h62);
    fetch(2, 8'h63);
    fetch(3, 8'h53);

    // reset in the middle of a load
    start_load();
    send(8'h71, 1'b0);
    send(8'h72, 1'b0);
    chk("mid_count", 32'(load_count), 32'd2);
    nReset = 1'b0;
    #1;
    chk("mid_ready", 32'(ld_if.ld_ready), 32'd0);
    chk("mid_cpu_nReset", 32'(cpu_nReset), 32'd0);
    chk("mid_ovf", 32'(load_ovf), 32'd0);
    chk("mid_count_rst", 32'(load_count), 32'd0);
    step();
    nReset = 1'b1;
    wait_run();
    fetch(0, 8'h71);
    fetch(1, 8'h72);
    fetch(2, 8'h63);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
